ipv4_multi_field_extractor: RTL and testbench

Parametrised successor to the single-field IPv4 header extractor. It watches an avln_st stream passively and does three things per packet: walks the Ethernet ethertype chain through up to MAX_VLAN_TAGS VLAN tags, detects IPv4, and captures N_FIELDS byte-addressed IPv4 header fields, including fields that straddle word boundaries. It sits beside the pass-through FIFO and feeds classification and debug display logic. It never back-pressures the stream.

---
 rtl/ipv4_multi_field_extractor_if.sv | 13 +
 rtl/ipv4_multi_field_extractor.sv | 220 ++++++++++++++++++++++
 tb/tb_ipv4_multi_field_extractor.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipv4_multi_field_extractor_if.sv
// Monitored byte stream: lane 0 occupies the top byte of data and is the
// earliest byte on the wire.
interface ipv4_multi_field_extractor_if #(
  parameter int W = 32
);
  logic [W-1:0] data;
  logic         valid;
  logic         sop;
  logic         eop;

  modport master (output data, valid, sop, eop);
  modport slave  (input  data, valid, sop, eop);
endinterface

// File: rtl/ipv4_multi_field_extractor.sv
// Passive stream monitor: walks the VLAN ethertype chain, detects IPv4 and
// captures byte-addressed IPv4 header fields, one status pulse per packet.
module ipv4_multi_field_extractor #(
  parameter int          BPW                  = 4,
  parameter int          N_FIELDS             = 4,
  parameter int unsigned FIELD_OFS [N_FIELDS] = '{0, 2, 9, 12},
  parameter int unsigned FIELD_LEN [N_FIELDS] = '{1, 2, 1, 4},
  parameter int          MAX_VLAN_TAGS        = 2,
  parameter int          ETYPE_BYTE           = 14
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  ipv4_multi_field_extractor_if.slave  in_i,
  output logic [N_FIELDS-1:0][31:0]    fields_o,
  output logic                         fields_valid_o,
  output logic                         not_ipv4_o,
  output logic                         truncated_o,
  output logic [1:0]                   vlan_count_o
);

  function automatic int max_end();
    int m;
    m = 0;
    for (int i = 0; i < N_FIELDS; i++) begin
      if (int'(FIELD_OFS[i] + FIELD_LEN[i]) > m) begin
        m = int'(FIELD_OFS[i] + FIELD_LEN[i]);
      end
    end
    return m;
  endfunction

  function automatic logic is_vlan(input logic [15:0] t);
    return (t == 16'h8100) || (t == 16'h88A8) || (t == 16'h9100);
  endfunction

  localparam int             MAX_END  = max_end();
  localparam int             MAX_BYTE = ETYPE_BYTE + 2 + 4 * MAX_VLAN_TAGS + MAX_END;
  localparam int             CNT      = $clog2(MAX_BYTE + 1);
  localparam logic [CNT-1:0] CNT_MAX  = '1;

  // Ethertype decisions must end on a word boundary so no word mixes
  // ethertype bytes with IPv4 header bytes.
  generate
    if (((ETYPE_BYTE + 2) % BPW != 0) || (4 % BPW != 0) ||
        (N_FIELDS < 1) || (N_FIELDS > 8) ||
        (MAX_VLAN_TAGS < 0) || (MAX_VLAN_TAGS > 3)) begin : g_bad_params
      $error("ipv4_multi_field_extractor: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ETYPE, FIELDS, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CNT-1:0]            byte_cnt_q, byte_cnt_d;
  logic [CNT-1:0]            ip_start_q, ip_start_d;
  logic [1:0]                tags_q, tags_d;
  logic [15:0]               etype_q, etype_d;
  logic [N_FIELDS-1:0][31:0] stage_q, stage_d;
  logic [N_FIELDS-1:0][31:0] fields_q, fields_d;
  logic                      fields_valid_q, fields_valid_d;
  logic                      not_ipv4_q, not_ipv4_d;
  logic                      truncated_q, truncated_d;
  logic [1:0]                vlan_count_q, vlan_count_d;

  // Next state, byte walk, field staging and status pulses for one accepted word.
  always_comb begin
    state_e st;
    int     base;
    int     idx;
    int     e_idx;
    int     fstart;
    logic   etype_done;
    logic   last_seen;

    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    ip_start_d     = ip_start_q;
    tags_d         = tags_q;
    etype_d        = etype_q;
    stage_d        = stage_q;
    fields_d       = fields_q;
    vlan_count_d   = vlan_count_q;
    fields_valid_d = 1'b0;
    not_ipv4_d     = 1'b0;
    truncated_d    = 1'b0;
    st             = state_q;
    base           = 0;
    idx            = 0;
    e_idx          = 0;
    fstart         = 0;
    etype_done     = 1'b0;
    last_seen      = 1'b0;

    if (in_i.valid) begin
      // A sop restarts the parse from this very word, whatever state we were in.
      if (in_i.sop) begin
        st      = ETYPE;
        base    = 0;
        tags_d  = 2'd0;
        stage_d = '0;
      end else begin
        base = int'(byte_cnt_q);
      end
      byte_cnt_d = (base + BPW > int'(CNT_MAX)) ? CNT_MAX : CNT'(base + BPW);
      e_idx      = ETYPE_BYTE + 4 * int'(tags_d);

      for (int k = 0; k < BPW; k++) begin
        idx = base + k;
        if (st == ETYPE) begin
          if (idx == e_idx) begin
            etype_d[15:8] = in_i.data[8*BPW-1-8*k -: 8];
          end else if (idx == e_idx + 1) begin
            etype_d[7:0] = in_i.data[8*BPW-1-8*k -: 8];
            etype_done   = 1'b1;
          end
        end else if (st == FIELDS) begin
          last_seen = last_seen | (idx == int'(ip_start_q) + MAX_END - 1);
          for (int i = 0; i < N_FIELDS; i++) begin
            fstart = int'(ip_start_q) + int'(FIELD_OFS[i]);
            if ((idx >= fstart) && (idx < fstart + int'(FIELD_LEN[i]))) begin
              stage_d[i][8*(fstart + int'(FIELD_LEN[i]) - 1 - idx) +: 8] =
                in_i.data[8*BPW-1-8*k -: 8];
            end
          end
        end
      end

      case (st)
        IDLE: begin
          state_d = IDLE;
        end
        ETYPE: begin
          if (etype_done) begin
            if (etype_d == 16'h0800) begin
              ip_start_d = CNT'(e_idx + 2);
              if (in_i.eop) begin
                truncated_d = 1'b1;
                state_d     = IDLE;
              end else begin
                state_d = FIELDS;
              end
            end else if (is_vlan(etype_d) && (int'(tags_d) < MAX_VLAN_TAGS)) begin
              if (in_i.eop) begin
                truncated_d = 1'b1;
                state_d     = IDLE;
              end else begin
                tags_d  = tags_d + 2'd1;
                state_d = ETYPE;
              end
            end else begin
              not_ipv4_d   = 1'b1;
              vlan_count_d = tags_d;
              state_d      = IDLE;
            end
          end else if (in_i.eop) begin
            truncated_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = ETYPE;
          end
        end
        FIELDS: begin
          if (last_seen) begin
            fields_valid_d = 1'b1;
            fields_d       = stage_d;
            vlan_count_d   = tags_d;
            state_d        = DONE;
          end else if (in_i.eop) begin
            truncated_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = FIELDS;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      byte_cnt_q     <= '0;
      ip_start_q     <= '0;
      tags_q         <= 2'd0;
      etype_q        <= 16'h0000;
      stage_q        <= '0;
      fields_q       <= '0;
      fields_valid_q <= 1'b0;
      not_ipv4_q     <= 1'b0;
      truncated_q    <= 1'b0;
      vlan_count_q   <= 2'd0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      ip_start_q     <= ip_start_d;
      tags_q         <= tags_d;
      etype_q        <= etype_d;
      stage_q        <= stage_d;
      fields_q       <= fields_d;
      fields_valid_q <= fields_valid_d;
      not_ipv4_q     <= not_ipv4_d;
      truncated_q    <= truncated_d;
      vlan_count_q   <= vlan_count_d;
    end
  end

  assign fields_o       = fields_q;
  assign fields_valid_o = fields_valid_q;
  assign not_ipv4_o     = not_ipv4_q;
  assign truncated_o    = truncated_q;
  assign vlan_count_o   = vlan_count_q;

endmodule

// File: tb/tb_ipv4_multi_field_extractor.sv
// Randomized and directed bench for ipv4_multi_field_extractor, checked
// cycle by cycle against a byte-level packet model.
module tb_ipv4_multi_field_extractor;

  localparam int NF        = 4;
  localparam int FOFS [NF] = '{0, 2, 9, 12};
  localparam int FLEN [NF] = '{1, 2, 1, 4};
  localparam int MAXT      = 2;
  localparam int EB        = 14;

  typedef byte unsigned bq_t [$];

  logic                sys_clk = 1'b0;
  logic                reset_n;
  logic [NF-1:0][31:0] fields_o;
  logic                fields_valid_o;
  logic                not_ipv4_o;
  logic                truncated_o;
  logic [1:0]          vlan_count_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Model prediction for the packet in flight, and the values the outputs hold.
  int                  exp_kind;
  int                  exp_byte;
  int                  exp_tags;
  logic [NF-1:0][31:0] exp_f;
  logic [NF-1:0][31:0] held_f;
  logic [1:0]          held_v;

  logic [15:0] ets [$];
  bq_t         hdr;
  bq_t         pkt;
  bq_t         plan_hdr;
  int          nt;

  ipv4_multi_field_extractor_if #(.W(32)) in_if ();

  ipv4_multi_field_extractor #(.BPW(4)) dut (
    .sys_clk        (sys_clk),
    .reset_n        (reset_n),
    .in_i           (in_if),
    .fields_o       (fields_o),
    .fields_valid_o (fields_valid_o),
    .not_ipv4_o     (not_ipv4_o),
    .truncated_o    (truncated_o),
    .vlan_count_o   (vlan_count_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic check_outputs(input logic [2:0] pulse);
    check_eq("pulse{fv,ni,tr}", {fields_valid_o, not_ipv4_o, truncated_o}, pulse);
    check_eq("fields", fields_o, held_f);
    check_eq("vlan_count", vlan_count_o, held_v);
  endtask

  // Walk the ethertype chain over the packet bytes and predict the outcome.
  task automatic predict(input bq_t b, input bit has_eop);
    int          len;
    int          t;
    int          e;
    int          ip;
    int          last;
    logic [15:0] et;
    bit          stop;
    len = b.size(); t = 0; stop = 1'b0;
    exp_kind = 0; exp_byte = 0; exp_f = '0;
    while (!stop) begin
      e = EB + 4 * t;
      if (e + 1 >= len) begin
        stop = 1'b1;
      end else begin
        et = {b[e], b[e+1]};
        if (et == 16'h0800) begin
          ip = e + 2; last = 0;
          for (int i = 0; i < NF; i++)
            if (ip + FOFS[i] + FLEN[i] - 1 > last) last = ip + FOFS[i] + FLEN[i] - 1;
          if (last < len) begin
            exp_kind = 1; exp_byte = last;
            for (int i = 0; i < NF; i++) begin
              exp_f[i] = 32'h0;
              for (int j = 0; j < FLEN[i]; j++) exp_f[i] = {exp_f[i][23:0], b[ip + FOFS[i] + j]};
            end
          end
          stop = 1'b1;
        end else if ((et == 16'h8100 || et == 16'h88A8 || et == 16'h9100) && t < MAXT) begin
          t++;
        end else begin
          exp_kind = 2; exp_byte = e + 1; stop = 1'b1;
        end
      end
    end
    exp_tags = t;
    if (exp_kind == 0 && has_eop) begin
      exp_kind = 3; exp_byte = len - 1;
    end
  endtask

  task automatic build(input logic [15:0] e_list [$], input bq_t h, input int nwords, output bq_t p);
    p = {};
    repeat (EB) p.push_back(8'($urandom));
    foreach (e_list[i]) begin
      p.push_back(e_list[i][15:8]);
      p.push_back(e_list[i][7:0]);
      if (i + 1 < e_list.size()) begin
        p.push_back(8'($urandom));
        p.push_back(8'($urandom));
      end
    end
    foreach (h[i]) p.push_back(h[i]);
    while (p.size() < 4 * nwords) p.push_back(8'($urandom));
    while (p.size() > 4 * nwords) void'(p.pop_back());
  endtask

  task automatic idle_cycle();
    in_if.valid = 1'b0;
    in_if.sop   = 1'($urandom);
    in_if.eop   = 1'($urandom);
    in_if.data  = $urandom;
    @(posedge sys_clk); #1;
    check_outputs(3'b000);
  endtask

  // gap_mode: 0 back-to-back, 1 idle before every word, 2 random idles.
  task automatic send_pkt(input bq_t b, input bit has_eop, input int gap_mode, input int rst_word);
    int         nw;
    logic [2:0] pulse;
    nw = b.size() / 4;
    predict(b, has_eop);
    for (int w = 0; w < nw; w++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) idle_cycle();
      in_if.valid = 1'b1;
      in_if.sop   = (w == 0);
      in_if.eop   = has_eop && (w == nw - 1);
      in_if.data  = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
      if (w == rst_word) begin
        reset_n = 1'b0;
        #1;
        held_f = '0; held_v = 2'd0;
        check_outputs(3'b000);
        @(posedge sys_clk); #1;
        check_outputs(3'b000);
        reset_n     = 1'b1;
        in_if.valid = 1'b0;
        return;
      end
      @(posedge sys_clk); #1;
      pulse = 3'b000;
      if (exp_kind != 0 && w == exp_byte / 4) begin
        case (exp_kind)
          1: begin pulse = 3'b100; held_f = exp_f; held_v = 2'(exp_tags); end
          2: begin pulse = 3'b010; held_v = 2'(exp_tags); end
          default: pulse = 3'b001;
        endcase
      end
      check_outputs(pulse);
    end
    in_if.valid = 1'b0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    in_if.valid = 1'b0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    in_if.data  = 32'h0;
    held_f      = '0;
    held_v      = 2'd0;
    plan_hdr    = {8'h45, 8'h00, 8'h00, 8'h54, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h06,
                   8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h02};
    repeat (2) @(posedge sys_clk);
    #1;
    check_outputs(3'b000);
    reset_n = 1'b1;

    // Stream noise before the first sop must be ignored.
    repeat (4) begin
      in_if.valid = 1'b1; in_if.sop = 1'b0; in_if.eop = 1'($urandom); in_if.data = 32'h08000800;
      @(posedge sys_clk); #1;
      check_outputs(3'b000);
    end
    in_if.valid = 1'b0;

    ets = {16'h0800};
    build(ets, plan_hdr, 9, pkt);
    send_pkt(pkt, 1'b1, 0, -1);
    check_eq("plan_f0", fields_o[0], 32'h00000045);
    check_eq("plan_f1", fields_o[1], 32'h00000054);
    check_eq("plan_f2", fields_o[2], 32'h00000006);
    check_eq("plan_f3", fields_o[3], 32'hC0A80001);
    check_eq("plan_vlan0", vlan_count_o, 2'd0);

    ets = {16'h8100, 16'h0800};
    build(ets, plan_hdr, 10, pkt);
    send_pkt(pkt, 1'b1, 0, -1);
    check_eq("tag1_f3", fields_o[3], 32'hC0A80001);
    check_eq("tag1_vlan", vlan_count_o, 2'd1);

    ets = {16'h88A8, 16'h8100, 16'h0800};
    build(ets, plan_hdr, 11, pkt);
    send_pkt(pkt, 1'b1, 0, -1);
    check_eq("qinq_vlan", vlan_count_o, 2'd2);

    ets = {16'h8100, 16'h8100, 16'h8100, 16'h0800};
    build(ets, plan_hdr, 12, pkt);
    send_pkt(pkt, 1'b1, 0, -1);
    check_eq("tag3_keep_f3", fields_o[3], 32'hC0A80001);

    ets = {16'h86DD};
    build(ets, plan_hdr, 9, pkt);
    send_pkt(pkt, 1'b1, 0, -1);

    ets = {16'h0800};
    build(ets, plan_hdr, 7, pkt);
    send_pkt(pkt, 1'b1, 0, -1);
    build(ets, plan_hdr, 8, pkt);
    send_pkt(pkt, 1'b1, 0, -1);
    build(ets, plan_hdr, 9, pkt);
    send_pkt(pkt, 1'b1, 1, -1);

    // Unfinished packet interrupted by a new sop, then reset mid-packet.
    build(ets, plan_hdr, 5, pkt);
    send_pkt(pkt, 1'b0, 0, -1);
    ets = {16'h9100, 16'h0800};
    build(ets, plan_hdr, 10, pkt);
    send_pkt(pkt, 1'b1, 0, -1);
    ets = {16'h0800};
    build(ets, plan_hdr, 9, pkt);
    send_pkt(pkt, 1'b1, 0, 4);
    build(ets, plan_hdr, 9, pkt);
    send_pkt(pkt, 1'b1, 0, -1);
    check_eq("post_rst_f0", fields_o[0], 32'h00000045);

    repeat (250) begin
      ets = {};
      nt  = $urandom_range(0, 3);
      for (int i = 0; i < nt; i++) begin
        case ($urandom_range(0, 3))
          0:       ets.push_back(16'h8100);
          1:       ets.push_back(16'h88A8);
          2:       ets.push_back(16'h9100);
          default: ets.push_back(16'($urandom));
        endcase
      end
      case ($urandom_range(0, 7))
        0:       ets.push_back(16'h86DD);
        1:       ets.push_back(16'($urandom));
        default: ets.push_back(16'h0800);
      endcase
      hdr = {};
      repeat (20) hdr.push_back(8'($urandom));
      build(ets, hdr, $urandom_range(3, 14), pkt);
      send_pkt(pkt, $urandom_range(0, 9) != 0, $urandom_range(0, 2), -1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
